// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed 7-segment scan controller:
//   SEG_TABLE  - 16-entry active-low hex glyph table, {dp,g,f,e,d,c,b,a}
//   SEG_BLANK  - all segments off
//   SEG_DASH   - middle bar only, shown on every digit on decimal overflow
//   segState_t - controller state (IDLE / CONV)
//   segPow10   - constant helper used to size the decimal overflow limit
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Index n holds the glyph for hex digit n; the dp bit (bit 7) is off here.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } segState_t;

  // 10^n as a 64-bit constant; 10^8 still fits comfortably.
  function automatic logic [63:0] segPow10(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) begin
      v = v * 64'd10;
    end
    return v;
  endfunction

endpackage

// File: rtl/seg_bcd_conv.sv
// ---------------------------------------------------------------------------
// seg_bcd_conv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock,
// 4*DIGITS clocks per conversion. Only instantiated when SEG_BCD_EN is set.
// Ports:
//   clk   - system clock, rising edge
//   RST   - asynchronous active-low reset, aborts a running conversion
//   start - begin converting bin (ignored while busy)
//   bin   - unsigned binary value, 4*DIGITS bits
//   busy  - conversion running
//   done  - high in the final conversion cycle; bcd is valid in that cycle
//   bcd   - DIGITS packed BCD digits (combinational, valid with done)
//   ovf   - bin was larger than 10^DIGITS-1; bcd is meaningless then
// ---------------------------------------------------------------------------
module seg_bcd_conv
  import seg_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);

  localparam int W    = 4 * DIGITS;
  localparam int CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [63:0]   MAXV = segPow10(DIGITS) - 64'd1;

  logic [W-1:0]  r_bin;
  logic [W-1:0]  r_bcd;
  logic [CW-1:0] r_cnt;
  logic          r_active;
  logic          r_ovf;
  logic [W-1:0]  w_adj;
  logic [W-1:0]  w_bcdNext;

  // Add-3 correction on every BCD digit that would overflow when doubled,
  // then shift the next binary MSB in. The result is exposed directly so
  // the parent can take it in the same cycle the last shift happens.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
    w_bcdNext = {w_adj[W-2:0], r_bin[W-1]};
  end

  // Conversion engine. Overflow is decided once from the captured input,
  // because the digit register is too narrow to hold an overflowing value.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (start && !r_active) begin
      r_bin    <= bin;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_ovf    <= ({{(64-W){1'b0}}, bin} > MAXV);
    end else if (r_active) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_bcdNext;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == LAST) begin
        r_active <= 1'b0;
      end
    end
  end

  assign busy = r_active;
  assign done = r_active && (r_cnt == LAST);
  assign bcd  = w_bcdNext;
  assign ovf  = r_ovf;

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed driver for DIGITS common-anode 7-segment digits. Each
// digit is lit for DIV clocks in turn; segments and anodes are registered.
// Optional decimal display is compiled in only when the macro SEG_BCD_EN
// is defined; otherwise mode is ignored and busy is tied low.
// Ports:
//   clk      - system clock, rising edge
//   RST      - asynchronous active-low reset
//   load     - one-cycle strobe capturing din / dp / mode
//   mode     - 0 hex display, 1 unsigned decimal display
//   din      - value to display, 4*DIGITS bits
//   dp       - decimal-point enables, bit i for digit i
//   blank_lz - leading-zero blanking, used live
//   busy     - decimal conversion in progress
//   SEG      - active-low segments {dp,g,f,e,d,c,b,a}
//   AN       - active-low one-hot digit enables
// ---------------------------------------------------------------------------
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                load,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] din,
  input  logic [DIGITS-1:0]   dp,
  input  logic                blank_lz,
  output logic                busy,
  output logic [7:0]          SEG,
  output logic [DIGITS-1:0]   AN
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(DIV);

  logic [PRE_W-1:0]    r_presc;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_disp;
  logic [DIGITS-1:0]   r_dpLatch;
  logic                r_ovf;
  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_an;

  logic                w_loadHex;
  logic                w_lastTick;
  logic                w_upperZero;
  logic                w_blank;
  logic [3:0]          w_nibble;
  logic [7:0]          w_segNext;
  logic [DIGITS-1:0]   w_anNext;

`ifdef SEG_BCD_EN
  segState_t           r_state;
  segState_t           w_stateNext;
  logic                w_busy;
  logic                w_startConv;
  logic                w_convBusy;
  logic                w_convDone;
  logic                w_convOvf;
  logic [4*DIGITS-1:0] w_convBcd;
  logic [DIGITS-1:0]   r_dpPend;

  // State register: IDLE while showing, CONV while the converter runs.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: a decimal load starts a conversion; the converter's final
  // cycle returns to IDLE together with the display update.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (load && mode) w_stateNext = CONV;
      CONV:    if (w_convDone || !w_convBusy) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Outputs of the FSM: loads are only accepted in IDLE, so a strobe that
  // arrives during a conversion is dropped.
  always_comb begin
    w_busy      = (r_state == CONV);
    w_startConv = (r_state == IDLE) && load && mode;
    w_loadHex   = (r_state == IDLE) && load && !mode;
  end

  // Decimal-point enables wait here until the converted digits land, so
  // the old display stays intact during conversion.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_dpPend <= '0;
    end else if (w_startConv) begin
      r_dpPend <= dp;
    end
  end

  seg_bcd_conv #(
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .RST   (RST),
    .start (w_startConv),
    .bin   (din),
    .busy  (w_convBusy),
    .done  (w_convDone),
    .bcd   (w_convBcd),
    .ovf   (w_convOvf)
  );

  assign busy = w_busy;
`else
  logic w_modeEff;

  // Without the converter every load is a hex load.
  assign w_modeEff = mode & 1'b0;
  assign w_loadHex = load && !w_modeEff;
  assign busy      = 1'b0;
`endif

  // Prescaler and digit index: the index advances once every DIV clocks.
  assign w_lastTick = (r_presc == PRE_W'(DIV - 1));

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_lastTick) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // Display register, dp latch and overflow flag. A hex load clears any
  // overflow left over from an earlier decimal conversion.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_disp    <= '0;
      r_dpLatch <= '0;
      r_ovf     <= 1'b0;
    end else if (w_loadHex) begin
      r_disp    <= din;
      r_dpLatch <= dp;
      r_ovf     <= 1'b0;
`ifdef SEG_BCD_EN
    end else if (w_convDone) begin
      r_disp    <= w_convBcd;
      r_dpLatch <= r_dpPend;
      r_ovf     <= w_convOvf;
`endif
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    w_upperZero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((i >= int'(r_idx)) && (r_disp[4*i +: 4] != 4'h0)) begin
        w_upperZero = 1'b0;
      end
    end
  end

  assign w_nibble = r_disp[{r_idx, 2'b00} +: 4];
  assign w_blank  = blank_lz && (r_idx != '0) && w_upperZero;
  assign w_anNext = ~(DIGITS'(1) << r_idx);

  // Segment selection, lowest to highest priority: glyph, dp, blanking,
  // overflow dash (which wins over blanking and clears dp).
  always_comb begin
    w_segNext = SEG_TABLE[w_nibble];
    if (r_dpLatch[r_idx]) begin
      w_segNext[7] = 1'b0;
    end
    if (w_blank) begin
      w_segNext = SEG_BLANK;
    end
    if (r_ovf) begin
      w_segNext = SEG_DASH;
    end
  end

  // Registered outputs so the pins change cleanly once per clock.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_seg <= w_segNext;
      r_an  <= w_anNext;
    end
  end

  assign SEG = r_seg;
  assign AN  = r_an;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Directed bench for seg_scan_ctrl with DIGITS=4, DIV=4. Expected segment
// and anode values are queued when stimulus is applied and popped when the
// matching digit is being driven. Decimal-mode steps are built only when
// SEG_BCD_EN is defined; the default build checks the hex fallback.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk      = 1'b0;
  logic        RST      = 1'b0;
  logic        load     = 1'b0;
  logic        mode     = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] din      = '0;
  logic [3:0]  dp       = '0;
  logic        busy;
  logic [7:0]  SEG;
  logic [3:0]  AN;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  segQ[$];
  logic [3:0]  anQ[$];

  seg_scan_ctrl #(
    .DIGITS (DIGITS),
    .DIV    (DIV)
  ) dut (
    .clk      (clk),
    .RST      (RST),
    .load     (load),
    .mode     (mode),
    .din      (din),
    .dp       (dp),
    .blank_lz (blank_lz),
    .busy     (busy),
    .SEG      (SEG),
    .AN       (AN)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Advance n clocks and settle 1 ns past the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle load strobe; returns 1 ns after the capturing edge.
  task automatic applyStimulus(input logic m, input logic [15:0] v, input logic [3:0] p);
    din  = v;
    dp   = p;
    mode = m;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic pushDigits(input logic [7:0] s3, input logic [7:0] s2,
                            input logic [7:0] s1, input logic [7:0] s0);
    segQ.push_back(s0);
    segQ.push_back(s1);
    segQ.push_back(s2);
    segQ.push_back(s3);
  endtask

  // Wait (bounded) for each digit 0..3 to be selected and compare SEG.
  task automatic scanDigits(input string tag);
    logic [3:0] want;
    logic [3:0] one;
    int budget;
    one = 4'b0001;
    tick(2);
    for (int d = 0; d < DIGITS; d++) begin
      want   = ~(one << d);
      budget = 0;
      while ((AN !== want) && (budget < 40)) begin
        tick(1);
        budget++;
      end
      if (AN !== want) begin
        checkOutput($sformatf("%s_an_timeout_d%0d", tag, d), {28'd0, AN}, {28'd0, want});
        void'(segQ.pop_front());
      end else begin
        checkOutput($sformatf("%s_d%0d", tag, d), {24'd0, SEG}, {24'd0, segQ.pop_front()});
      end
    end
  endtask

  // Two full scan rounds: each digit enable held for DIV clocks.
  task automatic checkAnSequence(input string tag);
    logic [3:0] one;
    one = 4'b0001;
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < DIGITS; d++)
        for (int c = 0; c < DIV; c++)
          anQ.push_back(~(one << d));
    for (int k = 0; k < 2 * DIGITS * DIV; k++) begin
      tick(1);
      checkOutput($sformatf("%s_cyc%0d", tag, k), {28'd0, AN}, {28'd0, anQ.pop_front()});
      if (k == 0) begin
        checkOutput({tag, "_seg_zero"}, {24'd0, SEG}, 32'hC0);
      end
    end
  endtask

  initial begin
    // Reset held from time zero
    tick(3);
    checkOutput("rst_seg",  {24'd0, SEG}, 32'hFF);
    checkOutput("rst_an",   {28'd0, AN},  32'hF);
    checkOutput("rst_busy", {31'd0, busy}, 32'h0);

    RST = 1'b1;
    checkAnSequence("an_first");

    // Hex load with dp on digit 0
    applyStimulus(1'b0, 16'h1A2F, 4'b0001);
    checkOutput("hex_busy0", {31'd0, busy}, 32'h0);
    tick(1);
    checkOutput("hex_busy1", {31'd0, busy}, 32'h0);
    pushDigits(8'hF9, 8'h88, 8'hA4, 8'h0E);
    scanDigits("hex1A2F");

    // Asynchronous reset in the middle of a scan period
    tick(1);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("midrst_seg",  {24'd0, SEG}, 32'hFF);
    checkOutput("midrst_an",   {28'd0, AN},  32'hF);
    checkOutput("midrst_busy", {31'd0, busy}, 32'h0);
    tick(2);
    RST = 1'b1;
    checkAnSequence("an_after_rst");

    // Leading-zero blanking, then the same value unblanked
    blank_lz = 1'b1;
    applyStimulus(1'b0, 16'h0050, 4'b0000);
    pushDigits(8'hFF, 8'hFF, 8'h92, 8'hC0);
    scanDigits("blank0050");
    blank_lz = 1'b0;
    pushDigits(8'hC0, 8'hC0, 8'h92, 8'hC0);
    scanDigits("noblank0050");

    // All-zero value: digit 0 stays lit, with its dp
    blank_lz = 1'b1;
    applyStimulus(1'b0, 16'h0000, 4'b0001);
    pushDigits(8'hFF, 8'hFF, 8'hFF, 8'h40);
    scanDigits("blank0000");
    blank_lz = 1'b0;

`ifdef SEG_BCD_EN
    // Decimal 1234: busy for exactly 16 clocks, mid-conversion load dropped
    applyStimulus(1'b1, 16'd1234, 4'b0000);
    checkOutput("dec_busy_c1", {31'd0, busy}, 32'h1);
    for (int i = 2; i <= 16; i++) begin
      if (i == 5) begin
        din  = 16'hFFFF;
        mode = 1'b0;
        load = 1'b1;
      end
      tick(1);
      load = 1'b0;
      checkOutput($sformatf("dec_busy_c%0d", i), {31'd0, busy}, 32'h1);
    end
    tick(1);
    checkOutput("dec_busy_end", {31'd0, busy}, 32'h0);
    pushDigits(8'hF9, 8'hA4, 8'hB0, 8'h99);
    scanDigits("dec1234");

    // Overflow dashes survive blanking
    blank_lz = 1'b1;
    applyStimulus(1'b1, 16'd10000, 4'b0000);
    tick(16);
    checkOutput("ovf_busy_end", {31'd0, busy}, 32'h0);
    pushDigits(8'hBF, 8'hBF, 8'hBF, 8'hBF);
    scanDigits("dec10000");
    blank_lz = 1'b0;

    applyStimulus(1'b1, 16'd9999, 4'b0000);
    tick(16);
    checkOutput("max_busy_end", {31'd0, busy}, 32'h0);
    pushDigits(8'h90, 8'h90, 8'h90, 8'h90);
    scanDigits("dec9999");
`else
    // Without the converter, mode=1 behaves as a hex load
    applyStimulus(1'b1, 16'h0012, 4'b0000);
    checkOutput("nobcd_busy0", {31'd0, busy}, 32'h0);
    tick(1);
    checkOutput("nobcd_busy1", {31'd0, busy}, 32'h0);
    pushDigits(8'hC0, 8'hC0, 8'hF9, 8'hA4);
    scanDigits("nobcd0012");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of 7-segment digits (1..8).
REQ-002 SHALL have parameter DIV, default 100000: clk cycles each digit is driven (>=2).
REQ-003 SHALL have port clk  in  1  single system clock, rising edge.
REQ-004 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port load  in  1  one-cycle strobe to capture din/dp/mode.
REQ-006 SHALL have port mode  in  1  0 = hex display, 1 = unsigned decimal display.
REQ-007 SHALL have port din  in  4*DIGITS  value to display.
REQ-008 SHALL have port dp  in  DIGITS  decimal-point enables, bit i = digit i.
REQ-009 SHALL have port blank_lz  in  1  leading-zero blanking enable, sampled live.
REQ-010 SHALL have port busy  out  1  decimal conversion in progress.
REQ-011 SHALL have port SEG  out  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.
REQ-012 SHALL have port AN  out  DIGITS  active-low digit enables, one-hot, registered.

Function
REQ-013 SHALL scan with prescaler counting 0..DIV-1; at DIV-1, digit index increments, wrapping DIGITS-1 -> 0.
REQ-014 SHALL drive AN[idx]=0, all other AN bits 1, and SEG = encoding of display nibble idx with dp[idx] applied.
REQ-015 SHALL use hex encoding 0..F, e.g. 0=8'hC0, 5=8'h92, F=8'h8E (dp off).
REQ-016 SHALL, on load with mode=0 and busy=0, update display register to din and dp latch to dp on the next cycle; busy stays 0.
REQ-017 SHALL, on load with mode=1 and busy=0, assert busy the next cycle for exactly 4*DIGITS cycles (shift-add-3 conversion), then update display and drop busy in the same cycle.
REQ-018 SHALL hold the previous display unchanged during conversion.
REQ-019 SHALL ignore load while busy=1.
REQ-020 SHALL, when decimal value exceeds 10^DIGITS-1, show dash 8'hBF on every digit with dp off.
REQ-021 SHALL, with blank_lz=1, show 8'hFF on digits above the most significant nonzero digit; digit 0 is never blanked; overflow dashes are never blanked.
REQ-022 SHALL use states IDLE -> CONV (load&mode) -> IDLE (shift count = 4*DIGITS-1).

Reset
REQ-023 SHALL, while RST=0, force SEG=8'hFF, AN all ones, busy=0, prescaler=0, idx=0, display=0, dp latch=0, state IDLE, independent of clk.
REQ-024 SHALL, on the first clk edge after RST release, drive AN[0]=0 showing digit 0.
REQ-025 SHALL abort any conversion on reset; display stays 0.

Configuration
REQ-026 SHALL compile decimal mode only when SEG_BCD_EN is defined.
REQ-027 SHALL, without SEG_BCD_EN, treat mode as 0, tie busy to 0, and omit CONV state and converter logic.

Structure
REQ-028 SHALL place the 16-entry segment table, SEG_BLANK (8'hFF), SEG_DASH (8'hBF) and the state enum in shared package seg_pkg.
REQ-029 SHALL implement conversion in sub-module seg_bcd_conv (start, bin, busy, done, bcd, ovf), instantiated only under SEG_BCD_EN.

Verification (DIGITS=4, DIV=4)
REQ-030 SHALL check: RST low mid-scan -> SEG=8'hFF, AN=4'hF immediately; after release AN = 1110, 1101, 1011, 0111, 4 cycles each, repeating.
REQ-031 SHALL check: load mode=0, din=16'h1A2F, dp=4'b0001 -> digit0 SEG=8'h0E, digit1 8'hA4, digit2 8'h88, digit3 8'hF9; busy stays 0.
REQ-032 SHALL check: load mode=1, din=16'd1234 -> busy high exactly 16 cycles; then digits 3..0 show 1,2,3,4; a load during busy is ignored.
REQ-033 SHALL check: load mode=1, din=16'd10000 -> all digits 8'hBF after 16 cycles; din=16'd9999 -> 9,9,9,9.
REQ-034 SHALL check: mode=0, din=16'h0050, blank_lz=1 -> digits 3,2 = 8'hFF, digit1 = 8'h92, digit0 = 8'hC0; blank_lz=0 -> digits 3,2 = 8'hC0.
REQ-035 SHALL check: without SEG_BCD_EN, load mode=1, din=16'h0012 -> hex digits 0,0,1,2 next cycle, busy=0.
